// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/data/status bundle between a FIFO user and the fifo_ctrl core.
interface fifo_ctrl_if #(parameter int DATA_WIDTH = 32);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic [2:0]            state;
   logic [3:0]            data_count;
   modport master (output wr_en, rd_en, din, input dout, state, data_count);
   modport slave (input wr_en, rd_en, din, output dout, state, data_count);
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: 8-entry FIFO state, pointers, occupancy and storage.
// Define FIFO_DOUT_CLEAR_EN to zero dout on every edge that does not perform a read.
module fifo_ctrl #(parameter int DATA_WIDTH = 32) (
   input logic        clk,
   input logic        reset_n,
   fifo_ctrl_if.slave bus
);
   localparam logic [2:0] INIT     = 3'b000;
   localparam logic [2:0] NO_OP    = 3'b001;
   localparam logic [2:0] WRITE    = 3'b010;
   localparam logic [2:0] WR_ERROR = 3'b011;
   localparam logic [2:0] READ     = 3'b100;
   localparam logic [2:0] RD_ERROR = 3'b101;
   logic [DATA_WIDTH-1:0] mem [8];
   logic [DATA_WIDTH-1:0] dout;
   logic [2:0]            state, nxt, head, tail;
   logic [3:0]            count;
   always_comb
      nxt = (bus.wr_en & ~bus.rd_en) ? ((count == 4'd8) ? WR_ERROR : WRITE) :
            (bus.rd_en & ~bus.wr_en) ? ((count == 4'd0) ? RD_ERROR : READ) : NO_OP;
   // Storage is deliberately not reset; the reset_n gate keeps a reset edge from writing.
   always_ff @(posedge clk)
      if (reset_n && nxt == WRITE) mem[tail] <= bus.din;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= INIT;
         count <= '0;
         head  <= '0;
         tail  <= '0;
         dout  <= '0;
      end else begin
         state <= nxt;
         if (nxt == WRITE) begin
            tail  <= tail + 3'd1;
            count <= count + 4'd1;
         end
         if (nxt == READ) begin
            head  <= head + 3'd1;
            count <= count - 4'd1;
         end
`ifdef FIFO_DOUT_CLEAR_EN
         dout <= (nxt == READ) ? mem[head] : '0;
`else
         if (nxt == READ) dout <= mem[head];
`endif
      end
   assign bus.state      = state;
   assign bus.data_count = count;
   assign bus.dout       = dout;
endmodule
